seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Sequential restoring divider for the calculator datapath. It is the inverse operation to
//   the combinational add/multiply units: it splits an 8-bit value into quotient and remainder
//   by a 4-bit divisor, producing one quotient bit per clock.
//   Sits beside the adder/multiplier and is driven by the calculator control FSM via start/done.
// PARAMETERS
//   DW  8  dividend and quotient width (bits); also the iteration count
//   VW  4  divisor and remainder width (bits)
// PORTS
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    request a division; sampled only in IDLE
//   dividend   in   DW   unsigned dividend; captured on the accepted start edge
//   divisor    in   VW   unsigned divisor; captured on the accepted start edge
//   busy       out  1    high whenever state != IDLE
//   done       out  1    single-cycle pulse; quotient/remainder/dbz valid from this cycle
//   quotient   out  DW   unsigned quotient; held until the next accepted start
//   remainder  out  VW   unsigned remainder; held until the next accepted start
//   dbz        out  1    divide-by-zero flag; held until the next accepted start
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quotient=0, remainder=0, dbz=0;
//     internal counter and work registers are 0. Reset during RUN aborts silently; no done pulse.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE + start=1 at edge k, divisor!=0:
//     capture operands; partial remainder (VW+1 bits)=0; shift register=dividend; count=0; go to RUN.
//   - IDLE + start=1 at edge k, divisor==0:
//     go to DONE; quotient={DW{1'b1}}, remainder=0, dbz=1. done is high in cycle k+1.
//   - RUN, each edge: R' = {R[VW-1:0], Q_msb}; shift Q left.
//     If R' >= {1'b0, divisor}: R = R'-divisor and Q lsb=1; else R = R' and Q lsb=0. count++.
//   - RUN, edge on which count reaches DW (edge k+DW): load quotient=Q and remainder=R[VW-1:0];
//     dbz=0; go to DONE.
//   - DONE: done=1 for exactly that cycle; next edge -> IDLE unconditionally.
//   - Latency: start edge k -> done high in the cycle after edge k+DW (8 RUN cycles at default).
//     Back-to-back throughput is one result per DW+2 cycles.
//   - start in RUN or DONE: ignored, with no effect on operands or timing.
//     Operand changes after the start edge: no effect.
//   - Outputs quotient/remainder/dbz change only on the edge entering DONE; stable otherwise.
//   - Width rules: partial remainder is VW+1 bits so the trial subtract never overflows.
//     Final remainder < divisor always fits VW bits. quotient <= dividend always fits DW bits.
//   - Fully synchronous datapath; the only asynchronous path is rst_n.
// TESTING
//   1. dividend=200, divisor=7, start pulse -> busy 1 for 9 cycles;
//      done after 8 RUN cycles; quotient=28, remainder=4, dbz=0.
//   2. dividend=255, divisor=15 -> quotient=17, remainder=0.
//      dividend=255, divisor=1 -> quotient=255, remainder=0.
//   3. dividend=5, divisor=9 -> quotient=0, remainder=5.
//      dividend=0, divisor=3 -> quotient=0, remainder=0.
//   4. dividend=13, divisor=0 -> done in the cycle after start; quotient=255, remainder=0, dbz=1.
//      A following 200/7 run clears dbz to 0.
//   5. start held high continuously with operands changing every cycle -> only the IDLE-sampled
//      operands are used; results arrive every 10 cycles; done is 1 cycle wide.
//   6. rst_n low during RUN cycle 4 of 100/3 -> all outputs 0 immediately, no done.
//      A new 100/3 after reset -> quotient=33, remainder=1.
//   Plus: exhaustive sweep over all 256x16 operand pairs against a reference model (/ and %).

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit unsigned divisor,
// one quotient bit per clock, with start/done handshake and divide-by-zero flag.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem;
    logic [DW-1:0] work;
    logic [VW:0]   trial;
    logic          fits;
    logic [VW-1:0] rem_next;
    logic [DW-1:0] work_next;
    logic          last;
    logic          accept;
    logic          zero_div;

    // After each restore the remainder is below the divisor, so only the trial needs VW+1 bits.
    always_comb begin
        trial     = {rem, work[DW-1]};
        fits      = (trial >= {1'b0, dvs});
        rem_next  = fits ? VW'(trial - {1'b0, dvs}) : trial[VW-1:0];
        work_next = {work[DW-2:0], fits};
    end

    assign last     = (count == CW'(DW - 1));
    assign accept   = (state == IDLE) && start;
    assign zero_div = (divisor == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            dvs       <= '0;
            rem       <= '0;
            work      <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (accept) begin
            count <= '0;
            dvs   <= divisor;
            rem   <= '0;
            work  <= dividend;
            if (zero_div) begin
                quotient  <= '1;
                remainder <= '0;
                dbz       <= 1'b1;
            end
        end else if (state == RUN) begin
            count <= count + CW'(1);
            rem   <= rem_next;
            work  <= work_next;
            if (last) begin
                quotient  <= work_next;
                remainder <= rem_next;
                dbz       <= 1'b0;
            end
        end
    end

endmodule
